// File: rtl/ctrl_pkg.sv
// Shared types for the RV32 pipelined control unit: opcodes, field enums,
// the EX control bundle and the decode function that builds it.
package ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_CSR = 2'b11
  } wb_sel_e;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_FUNCT  = 2'b10
  } alu_op_e;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_BUSY = 1'b1
  } seq_state_e;

  typedef struct packed {
    logic     reg_write;
    logic     mem_write;
    imm_src_e imm_src;
    logic     alu_src;
    logic     alu_src_a;
    wb_sel_e  wb_sel;
    alu_op_e  alu_op;
    logic     branch;
    logic     jump;
    logic     jalr;
    logic     muldiv;
    logic     csr;
  } ctrl_t;

  typedef struct packed {
    ctrl_t ctrl;
    logic  illegal;
  } dec_t;

  // An illegal encoding yields an all-zero bundle so nothing downstream can commit.
  function automatic dec_t decode(input logic [6:0] opcode, input logic [2:0] funct3,
                                  input logic [6:0] funct7, input logic en_mext,
                                  input logic en_csr);
    dec_t d;
    d = '0;
    case (opcode)
      OP_LOAD: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.alu_src   = 1'b1;
        d.ctrl.alu_src_a = 1'b1;
        d.ctrl.wb_sel    = WB_MEM;
      end
      OP_STORE: begin
        d.ctrl.mem_write = 1'b1;
        d.ctrl.imm_src   = IMM_S;
        d.ctrl.alu_src   = 1'b1;
        d.ctrl.alu_src_a = 1'b1;
      end
      OP_BRANCH: begin
        d.ctrl.branch  = 1'b1;
        d.ctrl.imm_src = IMM_B;
        d.ctrl.alu_op  = ALU_BRANCH;
      end
      OP_JAL: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.jump      = 1'b1;
        d.ctrl.imm_src   = IMM_J;
        d.ctrl.alu_src   = 1'b1;
        d.ctrl.wb_sel    = WB_PC4;
      end
      OP_JALR: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.jalr      = 1'b1;
        d.ctrl.alu_src   = 1'b1;
        d.ctrl.alu_src_a = 1'b1;
        d.ctrl.wb_sel    = WB_PC4;
      end
      OP_LUI, OP_AUIPC: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.imm_src   = IMM_U;
        d.ctrl.alu_src   = 1'b1;
      end
      OP_OP: begin
        if ((funct7 == F7_MULDIV) && !en_mext) begin
          d.illegal = 1'b1;
        end else begin
          d.ctrl.reg_write = 1'b1;
          d.ctrl.alu_src_a = 1'b1;
          d.ctrl.alu_op    = ALU_FUNCT;
          d.ctrl.muldiv    = (funct7 == F7_MULDIV);
        end
      end
      OP_OPIMM: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.alu_src   = 1'b1;
        d.ctrl.alu_src_a = 1'b1;
        d.ctrl.alu_op    = ALU_FUNCT;
      end
      OP_SYSTEM: begin
        // Only CSRRW/CSRRS/CSRRC (funct3 001..011) are implemented.
        if (en_csr && (funct3 != 3'b000) && (funct3[2] == 1'b0)) begin
          d.ctrl.reg_write = 1'b1;
          d.ctrl.alu_src_a = 1'b1;
          d.ctrl.wb_sel    = WB_CSR;
          d.ctrl.csr       = 1'b1;
        end else begin
          d.illegal = 1'b1;
        end
      end
      default: d.illegal = 1'b1;
    endcase
    if (d.illegal) begin
      d.ctrl = '0;
    end else begin
      d.ctrl = d.ctrl;
    end
    return d;
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// MUL/DIV residency sequencer: holds busy_o for LAT-1 cycles after a
// multi-cycle instruction is loaded into EX.
module muldiv_seq
  import ctrl_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic is_div_i,
  input  logic flush_i,
  output logic busy_o
);

  localparam logic [4:0] MUL_LAT = 5'(MUL_CYCLES);
  localparam logic [4:0] DIV_LAT = 5'(DIV_CYCLES);

  seq_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] lat_s;

  assign lat_s = is_div_i ? DIV_LAT : MUL_LAT;

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEQ_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: flush aborts; cnt counts down to the final busy cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      state_d = SEQ_IDLE;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        SEQ_IDLE: begin
          if (start_i && (lat_s > 5'd1)) begin
            state_d = SEQ_BUSY;
            cnt_d   = 4'(lat_s - 5'd2);
          end else begin
            state_d = SEQ_IDLE;
            cnt_d   = 4'd0;
          end
        end
        SEQ_BUSY: begin
          if (cnt_q == 4'd0) begin
            state_d = SEQ_IDLE;
            cnt_d   = 4'd0;
          end else begin
            state_d = SEQ_BUSY;
            cnt_d   = cnt_q - 4'd1;
          end
        end
        default: begin
          state_d = SEQ_IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // Output decode straight from the state register.
  always_comb begin
    busy_o = (state_q == SEQ_BUSY);
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined RV32 control unit: decodes into the EX register, forwards to WB,
// and handles stall, flush and multi-cycle MUL/DIV occupancy.
module pipe_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter bit          EN_MEXT    = 1'b0,
  parameter bit          EN_CSR     = 1'b0,
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid_i,
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  input  logic       stall_i,
  input  logic       flush_i,
  output logic       ex_valid_o,
  output ctrl_t      ex_ctrl_o,
  output logic       ex_illegal_o,
  output logic       wb_valid_o,
  output logic       wb_reg_write_o,
  output logic [1:0] wb_sel_o,
  output logic       busy_o
);

  dec_t  dec_s;
  logic  busy_s;
  logic  start_s;
  logic  ex_valid_q, ex_valid_d;
  ctrl_t ex_ctrl_q, ex_ctrl_d;
  logic  ex_illegal_q, ex_illegal_d;
  logic  wb_valid_q, wb_valid_d;
  logic  wb_reg_write_q, wb_reg_write_d;
  logic  [1:0] wb_sel_q, wb_sel_d;

  // Decode of the instruction currently in the decode stage.
  always_comb begin
    dec_s = decode(opcode_i, funct3_i, funct7_i, EN_MEXT, EN_CSR);
  end

  assign start_s = !flush_i && !busy_s && !stall_i && instr_valid_i && dec_s.ctrl.muldiv;

  muldiv_seq #(
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES)
  ) u_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_s),
    .is_div_i(funct3_i[2]),
    .flush_i (flush_i),
    .busy_o  (busy_s)
  );

  // Stage update: flush, then hold (busy/stall), then normal advance.
  always_comb begin
    ex_valid_d     = ex_valid_q;
    ex_ctrl_d      = ex_ctrl_q;
    ex_illegal_d   = ex_illegal_q;
    wb_valid_d     = ex_valid_q;
    wb_reg_write_d = ex_ctrl_q.reg_write;
    wb_sel_d       = ex_ctrl_q.wb_sel;
    if (flush_i) begin
      ex_valid_d   = 1'b0;
      ex_ctrl_d    = '0;
      ex_illegal_d = 1'b0;
    end else if (busy_s || stall_i) begin
      wb_valid_d     = 1'b0;
      wb_reg_write_d = 1'b0;
      wb_sel_d       = 2'b00;
    end else if (instr_valid_i) begin
      ex_valid_d   = 1'b1;
      ex_ctrl_d    = dec_s.ctrl;
      ex_illegal_d = dec_s.illegal;
    end else begin
      ex_valid_d   = 1'b0;
      ex_ctrl_d    = '0;
      ex_illegal_d = 1'b0;
    end
  end

  // EX and WB stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q     <= 1'b0;
      ex_ctrl_q      <= '0;
      ex_illegal_q   <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_sel_q       <= 2'b00;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_ctrl_q      <= ex_ctrl_d;
      ex_illegal_q   <= ex_illegal_d;
      wb_valid_q     <= wb_valid_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_sel_q       <= wb_sel_d;
    end
  end

  assign ex_valid_o     = ex_valid_q;
  assign ex_ctrl_o      = ex_ctrl_q;
  assign ex_illegal_o   = ex_illegal_q;
  assign wb_valid_o     = wb_valid_q;
  assign wb_reg_write_o = wb_reg_write_q;
  assign wb_sel_o       = wb_sel_q;
  assign busy_o         = busy_s;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: three configurations driven in lockstep and
// compared every cycle against a behavioural pipeline model.
module tb_pipe_ctrl_unit;

  localparam int NDUT = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       stall;
  logic       flush;

  logic        ex_valid   [NDUT];
  logic [15:0] ex_ctrl    [NDUT];
  logic        ex_illegal [NDUT];
  logic        wb_valid   [NDUT];
  logic        wb_rw      [NDUT];
  logic [1:0]  wb_sel     [NDUT];
  logic        busy       [NDUT];

  bit          m_ex_valid [NDUT];
  logic [15:0] m_ex_ctrl  [NDUT];
  bit          m_ex_ill   [NDUT];
  bit          m_wb_valid [NDUT];
  bit          m_wb_rw    [NDUT];
  logic [1:0]  m_wb_sel   [NDUT];
  int          m_left     [NDUT];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Config 0: M+CSR, MUL=2, DIV=4. Config 1: defaults. Config 2: M only, MUL=1, DIV=16.
  pipe_ctrl_unit #(.EN_MEXT(1'b1), .EN_CSR(1'b1), .MUL_CYCLES(2), .DIV_CYCLES(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .instr_valid_i(instr_valid), .opcode_i(opcode),
    .funct3_i(funct3), .funct7_i(funct7), .stall_i(stall), .flush_i(flush),
    .ex_valid_o(ex_valid[0]), .ex_ctrl_o(ex_ctrl[0]), .ex_illegal_o(ex_illegal[0]),
    .wb_valid_o(wb_valid[0]), .wb_reg_write_o(wb_rw[0]), .wb_sel_o(wb_sel[0]),
    .busy_o(busy[0]));

  pipe_ctrl_unit dut1 (
    .clk(clk), .rst_n(rst_n), .instr_valid_i(instr_valid), .opcode_i(opcode),
    .funct3_i(funct3), .funct7_i(funct7), .stall_i(stall), .flush_i(flush),
    .ex_valid_o(ex_valid[1]), .ex_ctrl_o(ex_ctrl[1]), .ex_illegal_o(ex_illegal[1]),
    .wb_valid_o(wb_valid[1]), .wb_reg_write_o(wb_rw[1]), .wb_sel_o(wb_sel[1]),
    .busy_o(busy[1]));

  pipe_ctrl_unit #(.EN_MEXT(1'b1), .EN_CSR(1'b0), .MUL_CYCLES(1), .DIV_CYCLES(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .instr_valid_i(instr_valid), .opcode_i(opcode),
    .funct3_i(funct3), .funct7_i(funct7), .stall_i(stall), .flush_i(flush),
    .ex_valid_o(ex_valid[2]), .ex_ctrl_o(ex_ctrl[2]), .ex_illegal_o(ex_illegal[2]),
    .wb_valid_o(wb_valid[2]), .wb_reg_write_o(wb_rw[2]), .wb_sel_o(wb_sel[2]),
    .busy_o(busy[2]));

  function automatic bit cfg_mext(int k); return (k != 1); endfunction
  function automatic bit cfg_csr(int k);  return (k == 0); endfunction
  function automatic int cfg_mul(int k);  return (k == 2) ? 1 : 2; endfunction
  function automatic int cfg_div(int k);  return (k == 0) ? 4 : ((k == 1) ? 8 : 16); endfunction

  // Returns {illegal, bundle}; bundle packs fields in the order they are listed for ex_ctrl_o.
  function automatic logic [16:0] ref_decode(int k, logic [6:0] op, logic [2:0] f3, logic [6:0] f7);
    bit ld, st, br, jl, jr, lui, aui, rr, oi, sys, md, csr_ok, ill;
    bit rw, asrc, asa;
    logic [2:0] imm;
    logic [1:0] wsel, aop;
    ld = (op == 7'h03); st = (op == 7'h23); br = (op == 7'h63); jl = (op == 7'h6f);
    jr = (op == 7'h67); lui = (op == 7'h37); aui = (op == 7'h17); rr = (op == 7'h33);
    oi = (op == 7'h13); sys = (op == 7'h73);
    md = rr && (f7 == 7'h01);
    csr_ok = (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd3);
    ill = !(ld | st | br | jl | jr | lui | aui | rr | oi | sys) ||
          (md && !cfg_mext(k)) || (sys && !(cfg_csr(k) && csr_ok));
    if (ill) return {1'b1, 16'h0000};
    rw   = ld | jl | jr | lui | aui | rr | oi | sys;
    imm  = st ? 3'd1 : br ? 3'd2 : jl ? 3'd3 : (lui | aui) ? 3'd4 : 3'd0;
    asrc = ld | st | oi | jl | jr | lui | aui;
    asa  = !(br | jl | lui | aui);
    wsel = ld ? 2'd1 : (jl | jr) ? 2'd2 : sys ? 2'd3 : 2'd0;
    aop  = br ? 2'd1 : (rr | oi) ? 2'd2 : 2'd0;
    return {1'b0, rw, st, imm, asrc, asa, wsel, aop, br, jl, jr, md, sys};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++) begin
      m_ex_valid[k] = 1'b0; m_ex_ctrl[k] = 16'h0000; m_ex_ill[k] = 1'b0;
      m_wb_valid[k] = 1'b0; m_wb_rw[k] = 1'b0; m_wb_sel[k] = 2'b00; m_left[k] = 0;
    end
  endtask

  // m_left = remaining cycles the EX instruction blocks the pipe after this one.
  task automatic model_edge(int k);
    logic [16:0] d;
    if (flush) begin
      m_wb_valid[k] = m_ex_valid[k]; m_wb_rw[k] = m_ex_ctrl[k][15]; m_wb_sel[k] = m_ex_ctrl[k][8:7];
      m_ex_valid[k] = 1'b0; m_ex_ctrl[k] = 16'h0000; m_ex_ill[k] = 1'b0; m_left[k] = 0;
    end else if (m_left[k] > 0 || stall) begin
      m_wb_valid[k] = 1'b0; m_wb_rw[k] = 1'b0; m_wb_sel[k] = 2'b00;
      if (m_left[k] > 0) m_left[k] = m_left[k] - 1;
    end else begin
      m_wb_valid[k] = m_ex_valid[k]; m_wb_rw[k] = m_ex_ctrl[k][15]; m_wb_sel[k] = m_ex_ctrl[k][8:7];
      d = ref_decode(k, opcode, funct3, funct7);
      m_ex_valid[k] = instr_valid;
      m_ex_ctrl[k]  = instr_valid ? d[15:0] : 16'h0000;
      m_ex_ill[k]   = instr_valid & d[16];
      m_left[k]     = (instr_valid && d[1]) ? ((funct3[2] ? cfg_div(k) : cfg_mul(k)) - 1) : 0;
    end
  endtask

  task automatic chk(string tag, int k, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d t=%0t observed=%h expected=%h", tag, k, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NDUT; k++) begin
      chk("ex_valid", k, 16'(ex_valid[k]), 16'(m_ex_valid[k]));
      chk("ex_ctrl", k, ex_ctrl[k], m_ex_ctrl[k]);
      chk("ex_illegal", k, 16'(ex_illegal[k]), 16'(m_ex_ill[k]));
      chk("wb_valid", k, 16'(wb_valid[k]), 16'(m_wb_valid[k]));
      chk("wb_reg_write", k, 16'(wb_rw[k]), 16'(m_wb_rw[k]));
      chk("wb_sel", k, 16'(wb_sel[k]), 16'(m_wb_sel[k]));
      chk("busy", k, 16'(busy[k]), 16'(m_left[k] > 0));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < NDUT; k++) begin
      if (!rst_n) model_reset();
      else model_edge(k);
    end
    #1;
    check_all();
  endtask

  task automatic drive(bit v, logic [6:0] op, logic [2:0] f3, logic [6:0] f7, bit st, bit fl);
    instr_valid = v; opcode = op; funct3 = f3; funct7 = f7; stall = st; flush = fl;
  endtask

  logic [6:0] ops [10] = '{7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h33, 7'h13, 7'h73};
  int nbusy;

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 7'h00, 3'd0, 7'h00, 1'b0, 1'b0);
    model_reset();
    #1;
    check_all();
    tick(); tick();
    @(negedge clk); rst_n = 1'b1;

    // lw
    drive(1'b1, 7'h03, 3'd2, 7'h00, 1'b0, 1'b0);
    tick();
    chk("lw_ex_wbsel", 0, 16'(ex_ctrl[0][8:7]), 16'd1);
    chk("lw_ex_imm", 0, 16'(ex_ctrl[0][13:11]), 16'd0);
    drive(1'b0, 7'h00, 3'd0, 7'h00, 1'b0, 1'b0);
    tick();
    chk("lw_wb_rw", 0, 16'(wb_rw[0]), 16'd1);
    chk("lw_wb_sel", 0, 16'(wb_sel[0]), 16'd1);

    // unknown opcode
    drive(1'b1, 7'h7f, 3'd0, 7'h00, 1'b0, 1'b0);
    tick();
    chk("ill_flag", 0, 16'(ex_illegal[0]), 16'd1);
    chk("ill_valid", 0, 16'(ex_valid[0]), 16'd1);
    drive(1'b0, 7'h00, 3'd0, 7'h00, 1'b0, 1'b0);
    tick();
    chk("ill_wb_rw", 0, 16'(wb_rw[0]), 16'd0);

    // DIV with LAT=4, lw waiting behind it
    drive(1'b1, 7'h33, 3'd4, 7'h01, 1'b0, 1'b0);
    tick();
    drive(1'b1, 7'h03, 3'd2, 7'h00, 1'b0, 1'b0);
    nbusy = 0;
    for (int i = 0; i < 6; i++) begin
      if (busy[0]) nbusy++;
      if (i == 4) chk("div_in_wb", 0, 16'({wb_valid[0], wb_rw[0]}), 16'd3);
      tick();
    end
    chk("div_busy_len", 0, 16'(nbusy), 16'd3);

    // MUL on a config without the M extension
    drive(1'b1, 7'h33, 3'd0, 7'h01, 1'b0, 1'b0);
    tick();
    chk("mul_noext_ill", 1, 16'(ex_illegal[1]), 16'd1);
    chk("mul_noext_busy", 1, 16'(busy[1]), 16'd0);
    drive(1'b0, 7'h00, 3'd0, 7'h00, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick();

    // DIV flushed on its 2nd busy cycle
    drive(1'b1, 7'h33, 3'd5, 7'h01, 1'b0, 1'b0);
    tick();
    drive(1'b0, 7'h00, 3'd0, 7'h00, 1'b0, 1'b0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", 0, 16'(busy[0]), 16'd0);
    chk("flush_exv", 0, 16'(ex_valid[0]), 16'd0);

    // asynchronous reset mid-BUSY
    drive(1'b1, 7'h33, 3'd6, 7'h01, 1'b0, 1'b0);
    tick();
    drive(1'b0, 7'h00, 3'd0, 7'h00, 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    tick();
    @(negedge clk); rst_n = 1'b1;
    drive(1'b1, 7'h03, 3'd2, 7'h00, 1'b0, 1'b0);
    tick();
    chk("post_rst_lw", 0, 16'(ex_ctrl[0][8:7]), 16'd1);
    tick();

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 7) != 0,
            ($urandom_range(0, 15) < 11) ? ops[$urandom_range(0, 9)] : 7'($urandom),
            3'($urandom),
            ($urandom_range(0, 3) < 2) ? 7'h01 : (($urandom_range(0, 1) == 0) ? 7'h00 : 7'($urandom)),
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 9) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
